// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a one-deep
// valid/ready output register with frame-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic [1:0] o_dbg_state
);

  // Output handshake: rx_data is transferred on any clk edge where rx_valid
  // and rx_ready are both high; rx_data is held stable while rx_valid is high.

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] C_HALF = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] C_FULL = 16'(CLKS_PER_BIT);

  state_t      r_state;
  logic        r_sync1;
  logic        r_rx_s;
  logic [1:0]  r_warm;
  logic        r_armed;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_busy;
  logic        r_ferr;
  logic        r_ovr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_warm  <= 2'b00;
      r_armed <= 1'b0;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync1 <= uart_rxd;
      r_rx_s  <= r_sync1;
      // r_warm[1] marks r_rx_s as carrying the real line, not reset values
      r_warm  <= {r_warm[0], 1'b1};
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      if (r_valid && rx_ready) r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_rx_s && r_warm[1]) r_armed <= 1'b1;
          if (!r_rx_s && r_armed) begin
            r_state <= START;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (r_cnt == C_HALF) begin
            r_cnt <= 16'd0;
            if (!r_rx_s) begin
              r_state <= DATA;
              r_idx   <= 3'd0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DATA: begin
          if (r_cnt == C_FULL) begin
            r_shift[r_idx] <= r_rx_s;
            r_cnt          <= 16'd0;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        STOP: begin
          if (r_cnt == C_FULL) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 16'd0;
            if (r_rx_s) begin
              if (!r_valid || rx_ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_ovr <= 1'b1;
              end
            end else begin
              // a held-low line must return high before another start is taken
              r_ferr  <= 1'b1;
              r_armed <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_busy      = r_busy;
  assign rx_frame_err = r_ferr;
  assign rx_overrun   = r_ovr;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=20 (21 clk per bit, 210 clk per frame).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic [1:0] o_dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_fall = 0;
  int t_valid = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int dbl_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       p_valid = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       p_ferr = 1'b0;
  logic       p_ovr = 1'b0;

  uart_rx #(.CLKS_PER_BIT(20)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rxd     (uart_rxd),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // output monitor: new bytes, flag pulses and flag widths
  always @(negedge clk) begin
    if (rx_valid === 1'b1 && (!p_valid || rx_data !== p_data)) begin
      got_q.push_back(rx_data);
      if (!p_valid) t_valid = cyc;
    end
    if (rx_frame_err === 1'b1) ferr_cnt++;
    if (rx_overrun === 1'b1) ovr_cnt++;
    if ((rx_frame_err === 1'b1 && p_ferr) || (rx_overrun === 1'b1 && p_ovr)) dbl_cnt++;
    p_valid = (rx_valid === 1'b1);
    p_data  = rx_data;
    p_ferr  = (rx_frame_err === 1'b1);
    p_ovr   = (rx_overrun === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // rmode: 0 ready low, 1 ready high throughout, 2 ready high only in the stop-sample cycle
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int rmode,
                            input int rst_on, input int rst_off);
    logic [9:0] bits;
    bits = {stop_b, b, 1'b0};
    for (int k = 0; k < 210; k++) begin
      @(negedge clk);
      if (k == 0) t_fall = cyc;
      uart_rxd = bits[k / 21];
      rx_ready = (rmode == 1) || (rmode == 2 && k == 202);
      if (k == rst_on) reset = 1'b1;
      if (k == rst_off) reset = 1'b0;
    end
    @(negedge clk);
    uart_rxd = 1'b1;
    if (rmode != 1) rx_ready = 1'b0;
  endtask

  initial begin
    int f0;
    int o0;
    int bc;
    int lat;
    reset    = 1'b1;
    uart_rxd = 1'b1;
    rx_ready = 1'b0;

    // reset values
    idle(5);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_busy", 32'(rx_busy), 32'h0);
    chk("rst_ferr", 32'(rx_frame_err), 32'h0);
    chk("rst_ovr", 32'(rx_overrun), 32'h0);
    chk("rst_state", 32'(o_dbg_state), 32'h0);
    reset = 1'b0;
    idle(10);

    // 0x3C with stop bit low
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 0, -1, -1);
    idle(5);
    chk("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
    chk("ferr_valid", 32'(rx_valid), 32'h0);
    chk("ferr_data", 32'(rx_data), 32'h00);
    chk("ferr_ovr", 32'(ovr_cnt), 32'd0);
    check_bytes("ferr");
    idle(20);

    // 0xA5 held until consumed
    send_frame(8'hA5, 1'b1, 0, -1, -1);
    lat = t_valid - t_fall;
    chk("a5_latency_window", 32'(lat >= 197 && lat <= 203), 32'h1);
    idle(50);
    chk("a5_valid_held", 32'(rx_valid), 32'h1);
    chk("a5_data", 32'(rx_data), 32'hA5);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    chk("a5_consumed", 32'(rx_valid), 32'h0);
    rx_ready = 1'b1;
    idle(3);
    rx_ready = 1'b0;
    chk("ready_idle_valid", 32'(rx_valid), 32'h0);
    chk("ready_idle_data", 32'(rx_data), 32'hA5);
    exp_q.push_back(8'hA5);
    check_bytes("a5");

    // back-to-back 0x00 / 0xFF with ready held high
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    send_frame(8'h00, 1'b1, 1, -1, -1);
    send_frame(8'hFF, 1'b1, 1, -1, -1);
    idle(5);
    rx_ready = 1'b0;
    chk("b2b_valid_off", 32'(rx_valid), 32'h0);
    chk("b2b_flags", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    check_bytes("b2b");

    // 5-clk glitch
    bc = 0;
    f0 = ferr_cnt;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      uart_rxd = (k < 5) ? 1'b0 : 1'b1;
      if (rx_busy === 1'b1) bc++;
    end
    chk("glitch_busy_max", 32'(bc <= 15), 32'h1);
    chk("glitch_busy_seen", 32'(bc > 0), 32'h1);
    chk("glitch_state", 32'(o_dbg_state), 32'h0);
    chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
    check_bytes("glitch");

    // overrun, then ready in the stop-sample cycle
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 0, -1, -1);
    idle(10);
    send_frame(8'h22, 1'b1, 0, -1, -1);
    idle(5);
    chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr_data_kept", 32'(rx_data), 32'h11);
    chk("ovr_valid_kept", 32'(rx_valid), 32'h1);
    send_frame(8'h22, 1'b1, 2, -1, -1);
    idle(5);
    chk("ovr_ready_no_pulse", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr_ready_data", 32'(rx_data), 32'h22);
    chk("ovr_ready_valid", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    check_bytes("ovr");
    idle(10);

    // reset during bit 4 of 0x5A, released during bit 7
    f0 = ferr_cnt;
    send_frame(8'h5A, 1'b1, 0, 110, 175);
    idle(30);
    chk("mrst_data", 32'(rx_data), 32'h00);
    chk("mrst_valid", 32'(rx_valid), 32'h0);
    chk("mrst_busy", 32'(rx_busy), 32'h0);
    chk("mrst_ferr", 32'(ferr_cnt - f0), 32'd0);
    check_bytes("mrst");
    send_frame(8'h5A, 1'b1, 0, -1, -1);
    idle(5);
    chk("mrst_next_data", 32'(rx_data), 32'h5A);
    exp_q.push_back(8'h5A);
    check_bytes("mrst_next");
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;

    // break: line low for over two frame times
    f0 = ferr_cnt;
    uart_rxd = 1'b0;
    idle(480);
    uart_rxd = 1'b1;
    idle(30);
    chk("break_ferr_once", 32'(ferr_cnt - f0), 32'd1);
    chk("break_busy", 32'(rx_busy), 32'h0);
    check_bytes("break");
    send_frame(8'h81, 1'b1, 0, -1, -1);
    idle(5);
    chk("after_break_data", 32'(rx_data), 32'h81);
    exp_q.push_back(8'h81);
    check_bytes("after_break");

    chk("flag_width", 32'(dbl_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
